// File: rtl/uarttx_fifo_if.sv
// Handshake bundle between the console write decode, uarttx_fifo and uarttx.
// master = system side (writer + uarttx), slave = the FIFO itself.
interface uarttx_fifo_if #(
  parameter int DepthBitWidth = 4
);
  logic                   wr_en;
  logic [7:0]             wr_data;
  logic                   full;
  logic                   empty;
  logic [DepthBitWidth:0] level;
  logic [7:0]             tx_data;
  logic                   tx_go;
  logic                   tx_bsy;
  logic [7:0]             drop_count;

  modport master (
    output wr_en, wr_data, tx_bsy,
    input  full, empty, level, tx_data, tx_go, drop_count
  );

  modport slave (
    input  wr_en, wr_data, tx_bsy,
    output full, empty, level, tx_data, tx_go, drop_count
  );
endinterface

// File: rtl/uarttx_fifo.sv
// Byte FIFO feeding uarttx through its go/bsy handshake, draining one byte per send.
// Optional UARTTX_FIFO_DROP_COUNT_EN builds a saturating counter of writes dropped while full.
module uarttx_fifo #(
  parameter int DepthBitWidth = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  uarttx_fifo_if.slave bus
);

  localparam int                     Depth    = 1 << DepthBitWidth;
  localparam logic [DepthBitWidth:0] DepthVal = (DepthBitWidth + 1)'(Depth);
  localparam logic [DepthBitWidth:0] PtrOne   = (DepthBitWidth + 1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BSY,
    WAIT_DONE,
    GAP
  } state_e;

  logic [7:0]             mem [Depth];
  logic [DepthBitWidth:0] wr_ptr_q, wr_ptr_d;
  logic [DepthBitWidth:0] rd_ptr_q, rd_ptr_d;
  state_e                 state_q, state_d;
  logic                   tx_go_q, tx_go_d;
  logic [7:0]             tx_data_q, tx_data_d;

  logic [DepthBitWidth:0] level;
  logic                   full;
  logic                   empty;
  logic                   push;

  // Extra pointer bit distinguishes full from empty when the indices coincide.
  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = (level == DepthVal);
  assign empty = (level == '0);
  assign push  = bus.wr_en && !full;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q[DepthBitWidth-1:0]] <= bus.wr_data;
    end
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    state_d   = state_q;
    tx_go_d   = tx_go_q;
    tx_data_d = tx_data_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end

    case (state_q)
      IDLE: begin
        if (!empty) begin
          tx_data_d = mem[rd_ptr_q[DepthBitWidth-1:0]];
          rd_ptr_d  = rd_ptr_q + PtrOne;
          tx_go_d   = 1'b1;
          state_d   = WAIT_BSY;
        end
      end
      WAIT_BSY: begin
        if (bus.tx_bsy) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_bsy) begin
          tx_go_d   = 1'b0;
          tx_data_d = 8'h00;
          state_d   = GAP;
        end
      end
      // One cycle with go low so uarttx re-arms before the next byte.
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      state_q   <= IDLE;
      tx_go_q   <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      state_q   <= state_d;
      tx_go_q   <= tx_go_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign bus.full    = full;
  assign bus.empty   = empty;
  assign bus.level   = level;
  assign bus.tx_go   = tx_go_q;
  assign bus.tx_data = tx_data_q;

`ifdef UARTTX_FIFO_DROP_COUNT_EN
  logic [7:0] drop_count_q, drop_count_d;

  always_comb begin
    drop_count_d = drop_count_q;
    if (bus.wr_en && full && (drop_count_q != 8'hFF)) begin
      drop_count_d = drop_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count_q <= 8'h00;
    end else begin
      drop_count_q <= drop_count_d;
    end
  end

  assign bus.drop_count = drop_count_q;
`else
  assign bus.drop_count = 8'h00;
`endif

endmodule

// File: tb/tb_uarttx_fifo.sv
// Randomized bench for uarttx_fifo: a queue-and-timeline model predicts every output each
// cycle, and the bench plays uarttx by driving tx_bsy from that model's own send schedule.
module tb_uarttx_fifo;

  localparam int DBW     = 4;
  localparam int DEPTH   = 1 << DBW;
  localparam int BIG     = 100000000;

  logic clk;
  logic rst_n;

  uarttx_fifo_if #(.DepthBitWidth(DBW)) bus ();

  uarttx_fifo #(.DepthBitWidth(DBW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: stored bytes plus the timeline of the byte currently being sent.
  logic [7:0] q[$];
  int         e;
  int         start;
  int         h;
  bit         have_start;
  int         pop_ok_at;
  bit         hold;
  int         fixed_h;
  logic [7:0] cur;
  int         drops;
  int         n_checks;
  int         n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, e);
    end
  endtask

  task automatic check_outputs();
    bit         exp_go;
    logic [7:0] exp_data;
    logic [7:0] exp_drop;
    exp_go   = have_start && (e >= start) && ((e - start) < h + 2);
    exp_data = exp_go ? cur : 8'h00;
`ifdef UARTTX_FIFO_DROP_COUNT_EN
    exp_drop = 8'(drops);
`else
    exp_drop = 8'h00;
`endif
    check("tx_go", 32'(bus.tx_go), 32'(exp_go));
    check("tx_data", 32'(bus.tx_data), 32'(exp_data));
    check("level", 32'(bus.level), 32'(q.size()));
    check("full", 32'(bus.full), 32'(q.size() == DEPTH));
    check("empty", 32'(bus.empty), 32'(q.size() == 0));
    check("drop_count", 32'(bus.drop_count), 32'(exp_drop));
  endtask

  task automatic step(input bit we, input logic [7:0] d);
    bit full_m;
    bit pop_m;
    bus.wr_en   = we;
    bus.wr_data = d;
    @(posedge clk);
    e++;
    full_m = (q.size() == DEPTH);
    pop_m  = (e >= pop_ok_at) && (q.size() != 0);
    if (we && full_m && drops < 255) drops++;
    if (pop_m) begin
      cur        = q.pop_front();
      start      = e;
      have_start = 1'b1;
      if (hold)             h = BIG;
      else if (fixed_h > 0) h = fixed_h;
      else                  h = int'($urandom_range(1, 6));
      pop_ok_at  = hold ? BIG : e + h + 4;
      $display("edge %0d: tx byte %02h sent, busy %0d cycles", e, cur, (h == BIG) ? -1 : h);
    end
    if (we && !full_m) q.push_back(d);
    #1;
    check_outputs();
    bus.tx_bsy = have_start && (e >= start + 1) && ((e - start) < h + 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  // Let uarttx finish the held byte: busy falls after the next edge.
  task automatic release_hold();
    hold = 1'b0;
    if (have_start && h == BIG) begin
      h         = e - start;
      pop_ok_at = start + h + 4;
    end
  endtask

  task automatic model_reset();
    q.delete();
    have_start = 1'b0;
    start      = 0;
    h          = 0;
    pop_ok_at  = 0;
    hold       = 1'b0;
    drops      = 0;
    cur        = 8'h00;
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    e           = 0;
    fixed_h     = 0;
    model_reset();
    rst_n       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.tx_bsy  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Single byte into an empty FIFO, busy held 10 cycles.
    fixed_h = 10;
    step(1'b1, 8'h41);
    idle(20);
    fixed_h = 0;

    // Back-to-back burst must come out in order with gaps between bytes.
    for (int i = 1; i <= 5; i++) step(1'b1, 8'(i));
    idle(60);

    // Busy stuck high: fill to full, drop one, then keep pushing to saturate the counter.
    hold = 1'b1;
    for (int i = 0; i < 18; i++) step(1'b1, 8'($urandom));
    check("level_full_hold", 32'(bus.level), 32'(DEPTH));
    for (int i = 0; i < 260; i++) step(1'b1, 8'($urandom));
    release_hold();
    // Keep writing across the pop edge so a push at full coincides with a pop.
    for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom));
    idle(200);

    // Randomized traffic, many pointer wraps, level sweeping through mid-range.
    for (int i = 0; i < 700; i++) begin
      step(($urandom_range(0, 3) == 0), 8'($urandom));
    end
    idle(200);

    // Reset in WAIT_DONE with 5 bytes still queued.
    hold = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'hA0 + i));
    idle(3);
    check("level_before_rst", 32'(bus.level), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    bus.tx_bsy = 1'b0;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    idle(20);
    step(1'b1, 8'h5A);
    idle(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "timeout");
  end

endmodule
